terminal_write_ctrl: RTL and testbench

Character-stream front end for the 80×32 VGA text buffer. It accepts 7-bit character and control codes from the keyboard/CPU path and tracks the cursor and hardware scroll position. It writes printable glyphs directly into the character RAM, and sequences the buffer-init engine for clear-screen, erase-to-end-of-line, scroll-line erase and status-row refresh. It sits immediately upstream of the buffer-init engine and shares the character RAM write port with it.

---
 rtl/terminal_write_ctrl_pkg.sv | 44 ++++
 rtl/init_req_handshake.sv | 35 +++
 rtl/terminal_write_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_terminal_write_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/terminal_write_ctrl_pkg.sv
// Shared definitions for the text-terminal write controller: control codes,
// screen geometry and controller state encoding.
package terminal_write_ctrl_pkg;

  // Control and fill codes understood by the character stream
  localparam logic [6:0] NUL         = 7'h00;
  localparam logic [6:0] BS          = 7'h08;
  localparam logic [6:0] TAB         = 7'h09;
  localparam logic [6:0] LF          = 7'h0A;
  localparam logic [6:0] VT          = 7'h0B;
  localparam logic [6:0] FF          = 7'h0C;
  localparam logic [6:0] CR          = 7'h0D;
  localparam logic [6:0] DC4         = 7'h14;
  localparam logic [6:0] STATUS_FILL = 7'h7F;

  // Screen geometry
  localparam int DEF_MAXCOL   = 80;
  localparam int SCREEN_CELLS = 2560;

  typedef enum logic [2:0] {
    CLS_REQ,
    CLS_WAIT,
    IDLE,
    WRITE,
    ERASE_REQ,
    ERASE_WAIT,
    STAT_REQ,
    STAT_WAIT
  } tw_state_e;

  // Glyph range that is written straight into character RAM
  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

  // Next tab stop (multiple of 8), clamped to the last column
  function automatic logic [6:0] next_tab(input logic [6:0] col,
                                          input logic [6:0] last);
    logic [7:0] t;
    t = {1'b0, col[6:3], 3'b000} + 8'd8;
    return (t > {1'b0, last}) ? last : t[6:0];
  endfunction

endpackage

// File: rtl/init_req_handshake.sv
// Request/done handshake with the buffer-init engine, shared by the
// clear-screen, erase and status-refresh paths.
module init_req_handshake (
  input  logic clk,
  input  logic reset,
  input  logic i_pulse,      // controller sits in a REQ state that starts the engine
  input  logic i_req,        // controller sits in any REQ state
  input  logic i_wait,       // controller sits in any WAIT state
  input  logic i_busy,       // engine owns the RAM
  output logic o_initEnable, // idles high, low for the request cycle
  output logic o_issued,     // request pulse is being driven this cycle
  output logic o_done        // WAIT may exit this cycle
);

  logic r_live;
  logic r_first;

  // r_live holds the enable high for the first cycle out of reset so the
  // engine, released in parallel, sees a clean falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  // Marks the first WAIT cycle, where busy may not have risen yet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_first <= 1'b0;
    else       r_first <= i_req;
  end

  assign o_initEnable = ~(i_pulse & r_live);
  assign o_issued     = r_live;
  assign o_done       = i_wait & ~r_first & ~i_busy;

endmodule

// File: rtl/terminal_write_ctrl.sv
// Character-stream front end for the 80x32 text buffer: tracks cursor and
// hardware scroll, writes glyphs, and sequences the init engine for
// clear-screen, erase-to-EOL, scroll-line erase and status-row refresh.
module terminal_write_ctrl
  import terminal_write_ctrl_pkg::*;
#(
  parameter int MAXCOL   = DEF_MAXCOL,
  parameter int TEXTROWS = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        charValid,
  input  logic [6:0]  charData,
  output logic        charReady,
  input  logic        initBusy,
  output logic        initEnable,
  output logic        initRowOnly,
  output logic        initSequential,
  output logic [4:0]  rowInitRow,
  output logic [6:0]  rowInitCol,
  output logic        updateStatusRow,
  output logic        wrEn,
  output logic [11:0] wrAddress,
  output logic [6:0]  wrData,
  output logic [4:0]  scrollRow,
  output logic [4:0]  cursorRow,
  output logic [6:0]  cursorCol
);

  localparam logic [6:0] LAST_COL = 7'(MAXCOL - 1);
  localparam logic [4:0] LAST_ROW = 5'(TEXTROWS - 1);

  tw_state_e  r_state;
  logic [4:0] r_scroll;
  logic [4:0] r_crow;
  logic [6:0] r_ccol;
  logic [6:0] r_char;
  logic [4:0] r_irow;
  logic [6:0] r_icol;
  logic       r_rowOnly;
  logic       r_seq;
  logic       r_fromScroll;

  logic [4:0] w_phys;
  logic       w_pulse;
  logic       w_req;
  logic       w_wait;
  logic       w_issued;
  logic       w_done;
  logic       w_lf;

  // Physical row wraps naturally in 5 bits
  assign w_phys  = r_scroll + r_crow;

  assign w_pulse = (r_state == CLS_REQ) || (r_state == ERASE_REQ);
  assign w_req   = w_pulse || (r_state == STAT_REQ);
  assign w_wait  = (r_state == CLS_WAIT) || (r_state == ERASE_WAIT) ||
                   (r_state == STAT_WAIT);

  // A line feed comes either from an LF code or from wrapping past the
  // last column after a glyph write.
  assign w_lf = ((r_state == IDLE) && charValid && (charData == LF)) ||
                ((r_state == WRITE) && !initBusy && (r_ccol == LAST_COL));

  init_req_handshake u_hs (
    .clk          (clk),
    .reset        (reset),
    .i_pulse      (w_pulse),
    .i_req        (w_req),
    .i_wait       (w_wait),
    .i_busy       (initBusy),
    .o_initEnable (initEnable),
    .o_issued     (w_issued),
    .o_done       (w_done)
  );

  // Controller FSM: cursor/scroll tracking and init-engine sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= CLS_REQ;
      r_scroll     <= '0;
      r_crow       <= '0;
      r_ccol       <= '0;
      r_char       <= '0;
      r_irow       <= '0;
      r_icol       <= '0;
      r_rowOnly    <= 1'b0;
      r_seq        <= 1'b0;
      r_fromScroll <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (charValid) begin
            if (is_printable(charData)) begin
              r_char  <= charData;
              r_state <= WRITE;
            end else begin
              case (charData)
                CR:  r_ccol <= '0;
                LF:  ; // handled by the shared line-feed rule below
                BS:  if (r_ccol != '0) r_ccol <= r_ccol - 7'd1;
                TAB: r_ccol <= next_tab(r_ccol, LAST_COL);
                VT: begin
                  r_irow       <= w_phys;
                  r_icol       <= r_ccol;
                  r_rowOnly    <= 1'b1;
                  r_fromScroll <= 1'b0;
                  r_state      <= ERASE_REQ;
                end
                FF, DC4: begin
                  r_seq     <= (charData == DC4);
                  r_rowOnly <= 1'b0;
                  r_irow    <= '0;
                  r_icol    <= '0;
                  r_crow    <= '0;
                  r_ccol    <= '0;
                  r_scroll  <= '0;
                  r_state   <= CLS_REQ;
                end
                NUL:     ;
                default: ;
              endcase
            end
          end
        end
        // Glyph strobe; held off while the engine still owns the RAM
        WRITE: begin
          if (!initBusy) begin
            r_state <= IDLE;
            if (r_ccol == LAST_COL) r_ccol <= '0;
            else                    r_ccol <= r_ccol + 7'd1;
          end
        end
        // Out of reset this state lasts an extra cycle so the pulse is clean
        CLS_REQ: if (w_issued) r_state <= CLS_WAIT;
        CLS_WAIT: begin
          if (w_done) begin
            r_seq   <= 1'b0;
            r_irow  <= r_scroll;
            r_icol  <= '0;
            r_state <= STAT_REQ;
          end
        end
        ERASE_REQ: r_state <= ERASE_WAIT;
        ERASE_WAIT: begin
          if (w_done) begin
            r_rowOnly    <= 1'b0;
            r_fromScroll <= 1'b0;
            if (r_fromScroll) begin
              r_irow  <= r_scroll;
              r_icol  <= '0;
              r_state <= STAT_REQ;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        STAT_REQ:  r_state <= STAT_WAIT;
        STAT_WAIT: if (w_done) r_state <= IDLE;
        default:   r_state <= CLS_REQ;
      endcase

      // Line feed: advance the cursor row, or scroll and erase the new line.
      // Placed last so the scroll path overrides the state chosen above.
      if (w_lf) begin
        if (r_crow < LAST_ROW) begin
          r_crow <= r_crow + 5'd1;
        end else begin
          r_scroll     <= r_scroll + 5'd1;
          r_irow       <= 5'(r_scroll + LAST_ROW + 5'd1);
          r_icol       <= '0;
          r_rowOnly    <= 1'b1;
          r_fromScroll <= 1'b1;
          r_state      <= ERASE_REQ;
        end
      end
    end
  end

  assign charReady       = (r_state == IDLE);
  assign updateStatusRow = (r_state == STAT_REQ);
  assign wrEn            = (r_state == WRITE) && !initBusy;
  assign wrAddress       = {r_ccol, w_phys};
  assign wrData          = r_char;
  assign initRowOnly     = r_rowOnly;
  assign initSequential  = r_seq;
  assign rowInitRow      = r_irow;
  assign rowInitCol      = r_icol;
  assign scrollRow       = r_scroll;
  assign cursorRow       = r_crow;
  assign cursorCol       = r_ccol;

endmodule

// File: tb/tb_terminal_write_ctrl.sv
// Scoreboard bench for terminal_write_ctrl: a behavioural terminal model
// queues expected RAM writes and init/status requests; a monitor pops and
// compares whenever the DUT emits one. A simple init-engine model drives
// initBusy.
module tb_terminal_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        charValid = 1'b0;
  logic [6:0]  charData = '0;
  logic        charReady;
  logic        initBusy;
  logic        initEnable;
  logic        initRowOnly;
  logic        initSequential;
  logic [4:0]  rowInitRow;
  logic [6:0]  rowInitCol;
  logic        updateStatusRow;
  logic        wrEn;
  logic [11:0] wrAddress;
  logic [6:0]  wrData;
  logic [4:0]  scrollRow;
  logic [4:0]  cursorRow;
  logic [6:0]  cursorCol;

  terminal_write_ctrl #(.MAXCOL(80), .TEXTROWS(31)) dut (
    .clk(clk), .reset(rst), .charValid(charValid), .charData(charData),
    .charReady(charReady), .initBusy(initBusy), .initEnable(initEnable),
    .initRowOnly(initRowOnly), .initSequential(initSequential),
    .rowInitRow(rowInitRow), .rowInitCol(rowInitCol),
    .updateStatusRow(updateStatusRow), .wrEn(wrEn), .wrAddress(wrAddress),
    .wrData(wrData), .scrollRow(scrollRow), .cursorRow(cursorRow),
    .cursorCol(cursorCol)
  );

  always #5 clk = ~clk;

  // kind 0: glyph write (a=addr, b=data); 1: init (a=rowOnly, b=seq, c=row, d=col);
  // 2: status refresh (a=row)
  typedef struct { int kind; int a; int b; int c; int d; } ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;
  int m_row, m_col, m_scr;

  // Init-engine model: busy for the fill length, starting the cycle after a request
  int eng_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)                  eng_cnt <= 0;
    else if (!initEnable)     eng_cnt <= initRowOnly ? (80 - int'(rowInitCol)) : 2560;
    else if (updateStatusRow) eng_cnt <= 80;
    else if (eng_cnt > 0)     eng_cnt <= eng_cnt - 1;
  end
  assign initBusy = (eng_cnt != 0);

  function automatic void push(input int k, input int a, input int b, input int c, input int d);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
    q.push_back(e);
  endfunction

  function automatic int phys();
    return (m_scr + m_row) % 32;
  endfunction

  function automatic void model_lf();
    if (m_row < 30) m_row++;
    else begin
      m_scr = (m_scr + 1) % 32;
      push(1, 1, 0, (m_scr + 30) % 32, 0);
      push(2, m_scr, 0, 0, 0);
    end
  endfunction

  function automatic void model_reset();
    m_row = 0; m_col = 0; m_scr = 0;
  endfunction

  // Terminal behaviour for one accepted code
  function automatic void model_char(input int c);
    if (c >= 32 && c <= 126) begin
      push(0, m_col * 32 + phys(), c, 0, 0);
      m_col++;
      if (m_col == 80) begin m_col = 0; model_lf(); end
    end else begin
      case (c)
        13: m_col = 0;
        10: model_lf();
        8:  if (m_col > 0) m_col--;
        9:  begin m_col = (m_col / 8 + 1) * 8; if (m_col > 79) m_col = 79; end
        11: push(1, 1, 0, phys(), m_col);
        12, 20: begin push(1, 0, (c == 20) ? 1 : 0, 0, 0); push(2, 0, 0, 0, 0); model_reset(); end
        default: ;
      endcase
    end
  endfunction

  task automatic expect_ev(input int k, input int a, input int b, input int c, input int d,
                           input string nm);
    ev_t e;
    bit ok;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event got a=%0h b=%0h c=%0h d=%0h", nm, a, b, c, d);
    end else begin
      e = q.pop_front();
      ok = (e.kind == k) && (e.a == a);
      if (k != 2) ok = ok && (e.b == b);
      if (k == 1 && e.a == 1) ok = ok && (e.c == c) && (e.d == d);
      if (!ok)
        $display("FAIL %s got kind=%0d a=%0h b=%0h c=%0h d=%0h exp kind=%0d a=%0h b=%0h c=%0h d=%0h",
                 nm, k, a, b, c, d, e.kind, e.a, e.b, e.c, e.d);
      if (!ok) errors++;
    end
  endtask

  // Monitor: compare every DUT-side event against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (wrEn) begin
        expect_ev(0, int'(wrAddress), int'(wrData), 0, 0, "glyph_write");
        checks++;
        if (initBusy) begin
          errors++;
          $display("FAIL wr_during_busy got wrEn=1 initBusy=%0b exp initBusy=0", initBusy);
        end
      end
      if (!initEnable)
        expect_ev(1, int'(initRowOnly), int'(initSequential), int'(rowInitRow),
                  int'(rowInitCol), "init_req");
      if (updateStatusRow)
        expect_ev(2, int'(rowInitRow), 0, 0, 0, "status_req");
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic check_pos(input string nm);
    chk({nm, "_row"}, int'(cursorRow), m_row);
    chk({nm, "_col"}, int'(cursorCol), m_col);
    chk({nm, "_scroll"}, int'(scrollRow), m_scr);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_charReady"}, int'(charReady), 0);
    chk({nm, "_initEnable"}, int'(initEnable), 1);
    chk({nm, "_wrEn"}, int'(wrEn), 0);
    chk({nm, "_updStatus"}, int'(updateStatusRow), 0);
    chk({nm, "_rowOnly"}, int'(initRowOnly), 0);
    chk({nm, "_seq"}, int'(initSequential), 0);
    chk({nm, "_cursor"}, int'({cursorRow, cursorCol}), 0);
    chk({nm, "_scroll"}, int'(scrollRow), 0);
  endtask

  // Offer one code at a negedge, hold until accepted (bounded)
  task automatic send(input int c);
    int t;
    charValid = 1'b1;
    charData  = 7'(c);
    t = 0;
    while (!charReady && t < 8000) begin @(negedge clk); t++; end
    if (!charReady) begin
      checks++; errors++;
      $display("FAIL ready_timeout got charReady=0 exp 1 code=%0h", c);
      charValid = 1'b0;
      return;
    end
    @(posedge clk);
    model_char(c);
    @(negedge clk);
    charValid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (!(charReady && q.size() == 0) && t < 8000) begin @(negedge clk); t++; end
    checks++;
    if (!(charReady && q.size() == 0)) begin
      errors++;
      $display("FAIL %s idle_timeout got charReady=%0b pending=%0d exp 1 0", nm, charReady, q.size());
    end
  endtask

  task automatic start_after_reset();
    model_reset();
    push(1, 0, 0, 0, 0);
    push(2, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int r, t;
    int others[6] = '{0, 1, 7, 27, 127, 21};
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    start_after_reset();
    wait_idle("power_on_clear");
    check_pos("power_on");

    // 'A' at home
    send(8'h41);
    wait_idle("first_glyph");
    check_pos("first_glyph");

    // Full line of glyphs on row 5 wraps to row 6 without any init request
    send(13);
    repeat (5) send(10);
    for (int i = 0; i < 80; i++) send(32 + $urandom_range(0, 94));
    wait_idle("full_line");
    check_pos("full_line");

    // Reach the bottom row, scroll up to scrollRow=31, then wrap to 0
    repeat (24) send(10);
    repeat (31) send(10);
    wait_idle("scroll31");
    check_pos("scroll31");
    send(10);
    wait_idle("scroll_wrap");
    check_pos("scroll_wrap");

    // Erase to end of line from column 40, with 'B' held pending
    repeat (5) send(9);
    send(11);
    send(8'h42);
    wait_idle("vt_then_B");
    check_pos("vt_then_B");

    // Reset in the middle of an erase wait
    send(11);
    t = 0;
    while (!initBusy && t < 100) begin @(negedge clk); t++; end
    chk("erase_busy_seen", int'(initBusy), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    q.delete();
    repeat (2) @(negedge clk);
    start_after_reset();
    wait_idle("reclear");
    check_pos("reclear");

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 60) send(32 + $urandom_range(0, 94));
      else if (r < 75) send(10);
      else if (r < 81) send(13);
      else if (r < 86) send(8);
      else if (r < 91) send(9);
      else if (r < 95) send(11);
      else if (r == 95) send(12);
      else if (r == 96) send(20);
      else send(others[$urandom_range(0, 5)]);
    end
    wait_idle("random");
    check_pos("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
